reg_bank: RTL

REG_BANK -- requirements
Module: reg_bank

---
 rtl/reg_bank_pkg.sv | 17 +
 rtl/reg_bank_scoreboard.sv | 71 +++++++
 rtl/reg_bank.sv | 124 ++++++++++++
 3 files changed

// File: rtl/reg_bank_pkg.sv
// -----------------------------------------------------------------------------
// reg_bank_pkg
// Shared constants and types for the reg_bank register file.
//   DEFAULT_WIDTH : default data width of every register
//   DEFAULT_DEPTH : default number of registers
//   DEFAULT_AW    : address width matching DEFAULT_DEPTH
//   bank_addr_t   : register index type for a default-sized bank
// -----------------------------------------------------------------------------
package reg_bank_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_DEPTH = 4;
    localparam int DEFAULT_AW    = $clog2(DEFAULT_DEPTH);

    typedef logic [DEFAULT_AW-1:0] bank_addr_t;

endpackage : reg_bank_pkg

// File: rtl/reg_bank_scoreboard.sv
// -----------------------------------------------------------------------------
// reg_bank_scoreboard
// Tracks which registers have a pending writeback (busy) and arbitrates claims.
// Ports:
//   clk_i        : clock, state updates on rising edge
//   reset_i      : asynchronous active-low reset, clears every busy bit
//   wr_en_i      : writeback strobe, clears busy[wr_addr_i]
//   wr_addr_i    : writeback register index
//   claim_en_i   : request to mark claim_addr_i busy
//   claim_addr_i : register index to claim
//   claim_ok_o   : claim accepted this cycle (combinational)
//   busy_o       : per-register busy vector
// -----------------------------------------------------------------------------
module reg_bank_scoreboard
    import reg_bank_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             wr_en_i,
    input  logic [AW-1:0]    wr_addr_i,
    input  logic             claim_en_i,
    input  logic [AW-1:0]    claim_addr_i,
    output logic             claim_ok_o,
    output logic [DEPTH-1:0] busy_o
);

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic             claim_free;

    // An out-of-range index matches no entry, so claim_free stays 0 and the
    // claim is rejected without any explicit range compare.
    always_comb begin
        claim_free = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (claim_addr_i == AW'(i)) begin
                claim_free = ~busy_q[i];
            end
        end
    end

    assign claim_ok_o = claim_en_i & claim_free;

    // Writeback clears first, an accepted claim sets afterwards, so a claim
    // and a writeback to the same index leave the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_i && (wr_addr_i == AW'(i))) begin
                busy_d[i] = 1'b0;
            end
            if (claim_ok_o && (claim_addr_i == AW'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_o = busy_q;

endmodule : reg_bank_scoreboard

// File: rtl/reg_bank.sv
// -----------------------------------------------------------------------------
// reg_bank
// Register file with one write port, two combinational read ports and a
// per-register busy scoreboard for pending writebacks.
// Optional feature: define REG_BANK_BYPASS_EN to forward write data to a read
// port addressing the register being written in the same cycle.
// Ports:
//   clk        : clock, all state updates on rising edge
//   reset      : asynchronous active-low reset, clears data and busy
//   wr_en      : write strobe (also completes a pending claim)
//   wr_addr    : write register index
//   wr_data    : write data
//   rd_a_addr  : read port A index     rd_b_addr  : read port B index
//   rd_a_data  : read port A data      rd_b_data  : read port B data
//   rd_a_valid : port A register idle  rd_b_valid : port B register idle
//   claim_en   : request to mark claim_addr busy
//   claim_addr : register to claim
//   claim_ok   : claim accepted this cycle
//   busy       : per-register busy vector
// -----------------------------------------------------------------------------
module reg_bank
    import reg_bank_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_a_addr,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_a_data,
    output logic [WIDTH-1:0] rd_b_data,
    output logic             rd_a_valid,
    output logic             rd_b_valid,
    input  logic             claim_en,
    input  logic [AW-1:0]    claim_addr,
    output logic             claim_ok,
    output logic [DEPTH-1:0] busy
);

    localparam int NPORTS = 2;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    logic [AW-1:0]    rd_addr  [NPORTS];
    logic [WIDTH-1:0] rd_data  [NPORTS];
    logic             rd_valid [NPORTS];

`ifdef REG_BANK_BYPASS_EN
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
    logic wr_in_range;
    assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
`endif

    reg_bank_scoreboard #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_scoreboard (
        .clk_i        (clk),
        .reset_i      (reset),
        .wr_en_i      (wr_en),
        .wr_addr_i    (wr_addr),
        .claim_en_i   (claim_en),
        .claim_addr_i (claim_addr),
        .claim_ok_o   (claim_ok),
        .busy_o       (busy)
    );

    // Writes to an index >= DEPTH match no entry and are dropped.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (wr_en && (wr_addr == AW'(i))) begin
                mem_d[i] = wr_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rd_addr[0] = rd_a_addr;
    assign rd_addr[1] = rd_b_addr;

    // Out-of-range read indices fall through the decode and return 0 / invalid.
    always_comb begin
        for (int p = 0; p < NPORTS; p++) begin
            rd_data[p]  = '0;
            rd_valid[p] = 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr[p] == AW'(i)) begin
                    rd_data[p]  = mem_q[i];
                    rd_valid[p] = ~busy[i];
                end
            end
`ifdef REG_BANK_BYPASS_EN
            if (wr_en && wr_in_range && (wr_addr == rd_addr[p])) begin
                rd_data[p]  = wr_data;
                rd_valid[p] = 1'b1;
            end
`endif
        end
    end

    assign rd_a_data  = rd_data[0];
    assign rd_a_valid = rd_valid[0];
    assign rd_b_data  = rd_data[1];
    assign rd_b_valid = rd_valid[1];

endmodule : reg_bank
